// File: rtl/ezp_tx_arb.sv
// Round-robin arbiter sharing one EZPack UART transmitter among NUM_REQ sources.
// Each granted packet is captured, launched with a one-cycle pulse, and the grant
// is held until the transmitter signals done or the WAIT timeout expires.
module ezp_tx_arb #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MAX_PKTLEN  = 7,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ*8*MAX_PKTLEN-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]                i_req_valid,
    output logic [NUM_REQ-1:0]                o_req_ready,
    output logic [8*MAX_PKTLEN-1:0]           o_tx_data,
    output logic                              o_tx_valid,
    input  logic                              i_tx_done,
    output logic                              o_busy,
    output logic [$clog2(NUM_REQ)-1:0]        o_grant_id,
    output logic                              o_err,
    output logic [15:0]                       o_pkt_cnt
);

    localparam int unsigned PW    = $clog2(NUM_REQ);
    localparam int unsigned TW    = $clog2(TIMEOUT_CYC);
    localparam int unsigned PKT_W = 8 * MAX_PKTLEN;

    localparam logic [PW-1:0] LAST_ID  = PW'(NUM_REQ - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_LAUNCH,
        ST_WAIT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   next_id;
    logic [31:0]     idx;
    logic            found;
    logic [TW-1:0]   tmo_cnt;
    logic            tmo_hit;
    logic [PKT_W-1:0] req_pkt [NUM_REQ];

    // Split the flat packet bus into one slice per requester.
    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            req_pkt[k] = i_req_data[k*PKT_W +: PKT_W];
        end
    end

    // Pick the first valid requester scanning upward from ptr; the wrap is an
    // explicit subtract so non-power-of-2 NUM_REQ works.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = PW'(idx);
            if (!found && i_req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign next_id = (o_grant_id == LAST_ID) ? '0 : o_grant_id + PW'(1);
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt   = state;
        o_req_ready = '0;
        o_tx_valid  = 1'b0;
        o_busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                o_req_ready[o_grant_id] = 1'b1;
                state_nxt = i_req_valid[o_grant_id] ? ST_LAUNCH : ST_IDLE;
            end
            ST_LAUNCH: begin
                o_tx_valid = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done || tmo_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Grant index, packet capture, timeout counter, completion count and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            o_grant_id <= '0;
            o_tx_data  <= '0;
            tmo_cnt    <= '0;
            o_pkt_cnt  <= '0;
            o_err      <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        o_grant_id <= sel;
                    end
                end
                ST_GRANT: begin
                    if (i_req_valid[o_grant_id]) begin
                        o_tx_data <= req_pkt[o_grant_id];
                    end
                end
                ST_LAUNCH: begin
                    tmo_cnt <= '0;
                end
                ST_WAIT: begin
                    // done has priority over a coincident timeout
                    if (i_tx_done) begin
                        o_pkt_cnt <= o_pkt_cnt + 16'd1;
                        ptr       <= next_id;
                    end else if (tmo_hit) begin
                        o_err <= 1'b1;
                        ptr   <= next_id;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ezp_tx_arb.sv
// Randomized and directed bench for ezp_tx_arb, checked every cycle against a
// transaction-level model built from cycle stamps of grant, launch and abort.
module tb_ezp_tx_arb;

    localparam int NR = 4;
    localparam int PL = 7;
    localparam int T  = 50;
    localparam int W  = 8 * PL;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*W-1:0]   i_req_data;
    logic [NR-1:0]     i_req_valid;
    logic [NR-1:0]     o_req_ready;
    logic [W-1:0]      o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_done;
    logic              o_busy;
    logic [1:0]        o_grant_id;
    logic              o_err;
    logic [15:0]       o_pkt_cnt;

    ezp_tx_arb #(.NUM_REQ(NR), .MAX_PKTLEN(PL), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst),
        .i_req_data(i_req_data), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_done(i_tx_done),
        .o_busy(o_busy), .o_grant_id(o_grant_id), .o_err(o_err), .o_pkt_cnt(o_pkt_cnt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // requester side
    logic [NR-1:0] v;
    logic [W-1:0]  pkt [NR];

    // reference model: cycle stamps instead of a state variable
    int          cyc = 0;
    int          m_ptr, m_gid, m_gcyc, m_lcyc, m_ecyc;
    logic [W-1:0] m_data;
    logic [15:0] m_cnt;
    int          done_at = -1;

    // knobs
    bit rand_req = 0, keep = 0, spur = 0, force_wd = 0, force_rst = 0, armed = 0;
    int dly_fix = 10, p_wd = 0, p_rst = 0;

    // observations
    logic [1:0] gq[$];
    int obs_launch = -1, obs_err = -1, first_gid = -1, err_pulses = 0, n_launch = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] rnd_pkt();
        return W'({$urandom(), $urandom()});
    endfunction

    task automatic present(input int k, input logic [W-1:0] d);
        if (!v[k]) begin
            v[k]   = 1'b1;
            pkt[k] = d;
        end
    endtask

    // One clock: check this cycle's outputs, drive inputs, advance the model.
    task automatic step();
        logic [NR-1:0] rdy_e;
        logic dn, r;
        int dly;
        rdy_e = (m_gcyc == cyc) ? NR'(1 << m_gid) : '0;
        if (armed) begin
            chk("ready",   64'(o_req_ready), 64'(rdy_e));
            chk("tx_valid",64'(o_tx_valid),  64'(m_lcyc == cyc));
            chk("busy",    64'(o_busy),      64'(m_gcyc >= 0));
            chk("grant_id",64'(o_grant_id),  64'(m_gid));
            chk("err",     64'(o_err),       64'(m_ecyc == cyc));
            chk("pkt_cnt", 64'(o_pkt_cnt),   64'(m_cnt));
            chk("tx_data", 64'(o_tx_data),   64'(m_data));
            if (o_tx_valid === 1'b1) begin
                obs_launch = cyc;
                n_launch++;
                gq.push_back(o_grant_id);
                if (first_gid < 0) first_gid = int'(o_grant_id);
            end
            if (o_err === 1'b1) begin
                obs_err = cyc;
                err_pulses++;
            end
        end
        // requester inputs for this cycle
        if (rand_req) begin
            for (int k = 0; k < NR; k++) begin
                if (!v[k] && $urandom_range(0, 3) == 0) begin
                    v[k]   = 1'b1;
                    pkt[k] = rnd_pkt();
                end
            end
        end
        if (cyc == m_gcyc && (force_wd || $urandom_range(0, 99) < p_wd)) begin
            v[m_gid] = 1'b0;
            force_wd = 0;
        end
        dn = (cyc == done_at) || (spur && $urandom_range(0, 31) == 0);
        r  = force_rst || ($urandom_range(0, 999) < p_rst);
        force_rst = 0;
        for (int k = 0; k < NR; k++) i_req_data[k*W +: W] = pkt[k];
        i_req_valid = v;
        i_tx_done   = dn;
        rst         = r;
        // model transition at the coming edge
        if (r) begin
            m_ptr = 0; m_gid = 0; m_data = '0; m_cnt = '0;
            m_gcyc = -1; m_lcyc = -1;
        end else if (m_gcyc < 0) begin
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (m_ptr + k) % NR;
                if (m_gcyc < 0 && v[c]) begin
                    m_gid  = c;
                    m_gcyc = cyc + 1;
                end
            end
        end else if (cyc == m_gcyc) begin
            if (v[m_gid]) begin
                m_data = pkt[m_gid];
                m_lcyc = cyc + 1;
                dly = (dly_fix < 0) ? int'($urandom_range(0, 60)) : dly_fix;
                done_at = (dly > 0) ? m_lcyc + dly : -1;
            end else begin
                m_gcyc = -1;
            end
        end else if (cyc > m_lcyc) begin
            if (dn) begin
                m_cnt  = m_cnt + 16'd1;
                m_ptr  = (m_gid + 1) % NR;
                m_gcyc = -1;
            end else if (cyc - m_lcyc == T) begin
                m_ecyc = cyc + 1;
                m_ptr  = (m_gid + 1) % NR;
                m_gcyc = -1;
            end
        end
        // completed handshakes
        for (int k = 0; k < NR; k++) begin
            if (v[k] && rdy_e[k]) begin
                if (keep) pkt[k] = rnd_pkt();
                else      v[k]   = 1'b0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic reset_dut();
        v = '0;
        force_rst = 1;
        step();
    endtask

    initial begin
        int l0;
        v = '0;
        for (int k = 0; k < NR; k++) pkt[k] = '0;
        m_ecyc = -1; m_gcyc = -1; m_lcyc = -1;
        m_ptr = 0; m_gid = 0; m_data = '0; m_cnt = '0;
        rst = 1'b1; i_req_valid = '0; i_req_data = '0; i_tx_done = 1'b0;
        @(negedge clk);
        reset_dut();
        armed = 1;

        // single request from requester 2
        dly_fix = 10;
        present(2, 56'h55_00_BE_EF_02_01_AA);
        run(14);
        chk("t1_cnt", 64'(o_pkt_cnt), 64'd1);
        chk("t1_busy", 64'(o_busy), 64'd0);

        // all four continuously valid, done 20 cycles after each launch
        reset_dut();
        keep = 1; dly_fix = 20;
        gq.delete();
        for (int k = 0; k < NR; k++) present(k, rnd_pkt());
        for (int i = 0; i < 400 && gq.size() < 6; i++) step();
        chk("t2_launches", 64'(gq.size()), 64'd6);
        run(20);
        chk("t2_cnt", 64'(o_pkt_cnt), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < gq.size()) chk("t2_order", 64'(gq[i]), 64'(i % 4));
        end
        keep = 0;

        // timeout abort
        reset_dut();
        dly_fix = 0;
        obs_err = -1; obs_launch = -1;
        present(1, rnd_pkt());
        for (int i = 0; i < 120 && obs_err < 0; i++) step();
        chk("t3_err_lat", 64'(obs_err - obs_launch), 64'(T + 1));
        first_gid = -1;
        for (int k = 0; k < NR; k++) present(k, rnd_pkt());
        for (int i = 0; i < 20 && first_gid < 0; i++) step();
        chk("t3_next_gid", 64'(first_gid), 64'd2);
        chk("t3_cnt", 64'(o_pkt_cnt), 64'd0);

        // done coincident with the timeout cycle
        reset_dut();
        dly_fix = T; err_pulses = 0;
        present(3, rnd_pkt());
        run(56);
        chk("t4_no_err", 64'(err_pulses), 64'd0);
        chk("t4_cnt", 64'(o_pkt_cnt), 64'd1);

        // requester 1 withdraws during GRANT
        reset_dut();
        dly_fix = 5;
        present(0, rnd_pkt());
        run(10);
        l0 = n_launch;
        force_wd = 1;
        present(1, rnd_pkt());
        run(4);
        chk("t5_no_launch", 64'(n_launch - l0), 64'd0);
        first_gid = -1;
        present(0, rnd_pkt());
        present(1, rnd_pkt());
        run(4);
        chk("t5_ptr_kept", 64'(first_gid), 64'd1);
        run(10);

        // reset in WAIT, then requester 0 wins
        reset_dut();
        dly_fix = 0;
        present(2, rnd_pkt());
        run(6);
        force_rst = 1;
        step();
        chk("t6_busy", 64'(o_busy), 64'd0);
        first_gid = -1;
        present(3, rnd_pkt());
        present(0, rnd_pkt());
        run(4);
        chk("t6_gid", 64'(first_gid), 64'd0);

        // randomized traffic
        reset_dut();
        rand_req = 1; spur = 1; dly_fix = -1; p_wd = 5; p_rst = 2;
        run(4000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ezp_tx_arb.md
# ezp_tx_arb

Round-robin arbiter that shares one EZPack UART transmitter between `NUM_REQ` packet sources. Each source presents a complete, framed EZPack packet with a valid/ready handshake. The arbiter grants one source at a time, captures its packet, and launches it into `ezp_uart_tx`. It holds the grant until the transmitter reports completion or a timeout expires. It sits between the packet producers (RX loopback path, status/telemetry generators) and the single `ezp_uart_tx` instance in the top level.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `MAX_PKTLEN`, 7: packet length in bytes; must match the `ezp_uart_tx` parameter.
- `TIMEOUT_CYC`, 1_000_000: maximum number of cycles spent in WAIT before abort; must be ≥ 2.

Ports:
- `clk`  in  1: system clock; the only clock.
- `rst`  in  1: reset; synchronous, active-high.
- `i_req_data`  in  `NUM_REQ*8*MAX_PKTLEN`: packet bus; requester k occupies bits `[k*8*MAX_PKTLEN +: 8*MAX_PKTLEN]`.
- `i_req_valid`  in  `NUM_REQ`: per-requester packet valid.
- `o_req_ready`  out  `NUM_REQ`: per-requester accept; one-hot or zero.
- `o_tx_data`  out  `8*MAX_PKTLEN`: captured packet, driven to `ezp_uart_tx.i_data`.
- `o_tx_valid`  out  1: one-cycle launch pulse, driven to `ezp_uart_tx.i_valid`.
- `i_tx_done`  in  1: completion pulse from `ezp_uart_tx.o_tx_done`.
- `o_busy`  out  1: high whenever the state is not IDLE.
- `o_grant_id`  out  `$clog2(NUM_REQ)`: index of the current or last granted requester.
- `o_err`  out  1: one-cycle pulse on timeout abort.
- `o_pkt_cnt`  out  16: count of packets completed via `i_tx_done`; wraps at 0xFFFF→0.

## Operation

- States: IDLE, GRANT, LAUNCH, WAIT. All outputs are registered or decoded from state only (Moore machine).
- IDLE:
  - If any `i_req_valid` bit is high, select the first set bit scanning upward from `ptr` with wrap-around.
  - Register the selection in `o_grant_id` and go to GRANT. Otherwise stay in IDLE.
- GRANT:
  - `o_req_ready[o_grant_id]` = 1; all other ready bits are 0.
  - If `i_req_valid[o_grant_id]` is high, latch that requester's slice into `o_tx_data` and go to LAUNCH.
  - If it is low (illegal withdrawal), go to IDLE with no launch and leave `ptr` unchanged.
- LAUNCH: `o_tx_valid` = 1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - On `i_tx_done`: increment `o_pkt_cnt`, set `ptr = (o_grant_id + 1) mod NUM_REQ`, go to IDLE.
  - Otherwise, when the counter reaches `TIMEOUT_CYC-1`: pulse `o_err` on the next cycle, set `ptr = o_grant_id + 1` (wrapping), go to IDLE.
  - If `i_tx_done` and timeout occur in the same cycle, done wins and no `o_err` is raised.
- `ptr` width is `$clog2(NUM_REQ)`. Wrap uses an explicit compare against `NUM_REQ-1`, because `NUM_REQ` need not be a power of 2.
- The timeout counter width is `$clog2(TIMEOUT_CYC)`; it saturates and never wraps.
- `o_tx_data` holds its value from the GRANT exit until the next capture.
- `i_tx_done` seen outside WAIT is ignored.
- Requester rule: hold `i_req_valid` and data stable until `o_req_ready` is observed. A transfer occurs on any edge where `valid & ready` are both high.

## Timing

- Reset values: state IDLE, `ptr` 0, `o_req_ready` 0, `o_tx_valid` 0, `o_tx_data` 0, `o_grant_id` 0, `o_busy` 0, `o_err` 0, `o_pkt_cnt` 0.
- Reset is legal in any state. Any packet in flight is dropped and not counted; the requester must re-present it.
- Cycle sequence, with valid sampled in cycle 0 in IDLE:
  - Cycle 1: GRANT, ready high.
  - Cycle 2: LAUNCH, `o_tx_valid` high, data stable.
  - Cycle 3 onward: WAIT.
- Latency from valid to launch pulse: 2 cycles.
- After `i_tx_done` is sampled in cycle D: IDLE in D+1, the earliest next GRANT in D+2.
- Timeout: with LAUNCH in cycle L, the abort edge ends cycle L+`TIMEOUT_CYC`; `o_err` is high in cycle L+`TIMEOUT_CYC`+1.
- `o_busy` is high from GRANT through the last WAIT cycle inclusive.

## Test plan

- Reset, then single request: `NUM_REQ`=4, requester 2 presents `0x55_xx_BEEF_02_01_AA`.
  - Required: ready[2] is high one cycle later; `o_tx_valid` pulses two cycles after valid with identical data.
  - After a `i_tx_done` pulse: `o_pkt_cnt`=1, and `o_busy` falls the next cycle.
- All four requesters valid continuously, `i_tx_done` returned 20 cycles after each launch.
  - Required: grant order 0,1,2,3,0,1; each ready bit one-hot; `o_pkt_cnt`=6.
- Timeout: `TIMEOUT_CYC`=50, `i_tx_done` never driven.
  - Required: `o_err` pulses exactly 51 cycles after the LAUNCH cycle; the next grant goes to the next index; `o_pkt_cnt` is unchanged.
- Done and timeout coincident (`i_tx_done` in cycle L+50 with `TIMEOUT_CYC`=50).
  - Required: no `o_err`; `o_pkt_cnt` increments.
- Requester 1 drops valid during GRANT: required no `o_tx_valid`, return to IDLE, `ptr` still 1.
- Assert `rst` for one cycle during WAIT: required all outputs at reset values the next cycle, then requester 0 wins the next arbitration.
